// File: rtl/wb_mux_n.sv
// Wishbone 1-to-N interconnect with registered address decode.
// Unmapped addresses and silent slaves get an error ack; error acks are counted.
module wb_mux_n #(
  parameter int                NUM_PERIPH = 4,
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                DEC_LSB    = 24,
  parameter int                TIMEOUT    = 255,
  parameter logic [DATA_W-1:0] ERR_DATA   = 32'hBADC0FFE,
  localparam int               SEL_W      = DATA_W / 8,
  localparam int               IDX_W      = $clog2(NUM_PERIPH)
) (
  input  logic                         io_wbs_clk,
  input  logic                         io_wbs_rst_n,
  input  logic [ADDR_W-1:0]            io_wbs_adr,
  input  logic [DATA_W-1:0]            io_wbs_datwr,
  output logic [DATA_W-1:0]            io_wbs_datrd,
  input  logic                         io_wbs_we,
  input  logic [SEL_W-1:0]             io_wbs_sel,
  input  logic                         io_wbs_stb,
  input  logic                         io_wbs_cyc,
  output logic                         io_wbs_ack,
  output logic [ADDR_W-1:0]            io_wbs_adr_p,
  output logic [DATA_W-1:0]            io_wbs_datwr_p,
  output logic                         io_wbs_we_p,
  output logic [SEL_W-1:0]             io_wbs_sel_p,
  output logic [NUM_PERIPH-1:0]        io_wbs_stb_p,
  output logic [NUM_PERIPH-1:0]        io_wbs_cyc_p,
  input  logic [NUM_PERIPH-1:0]        io_wbs_ack_p,
  input  logic [NUM_PERIPH*DATA_W-1:0] io_wbs_datrd_p,
  output logic                         err_o,
  output logic [7:0]                   err_cnt_o
);

  // state  | meaning
  // S_IDLE | no transaction; waits for cyc & stb
  // S_WAIT | selected slave strobed; waiting for its ack, abort or timeout
  // S_RESP | one-cycle master ack with captured slave data
  // S_ERR  | one-cycle error ack with ERR_DATA (unmapped or timed out)
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_ERR} state_t;

  localparam logic [IDX_W:0] NUM_P    = (IDX_W+1)'(NUM_PERIPH);
  localparam logic [15:0]    TMR_LOAD = 16'(TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    adr_idx;
  logic [15:0]         tmr;
  logic [DATA_W-1:0]   cap;
  logic [DATA_W-1:0]   sel_dat;
  logic                sel_ack;
  logic [NUM_PERIPH-1:0] onehot;
  logic                req, mapped;
  logic                latch, cap_en, tmr_dec, err_inc;

  assign req     = io_wbs_cyc & io_wbs_stb;
  assign adr_idx = io_wbs_adr[DEC_LSB +: IDX_W];
  assign mapped  = {1'b0, adr_idx} < NUM_P;

  // Slave mux; only the latched index is ever looked at, so other acks are ignored.
  always_comb begin
    sel_dat = '0;
    sel_ack = 1'b0;
    onehot  = '0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_dat   = io_wbs_datrd_p[i*DATA_W +: DATA_W];
        sel_ack   = io_wbs_ack_p[i];
        onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) state <= S_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    cap_en    = 1'b0;
    tmr_dec   = 1'b0;
    err_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          latch     = 1'b1;
          state_nxt = mapped ? S_WAIT : S_ERR;
          err_inc   = !mapped;
        end
      end
      S_WAIT: begin
        // Abort wins over a coincident slave ack; ack wins over timeout.
        if (!io_wbs_cyc) begin
          state_nxt = S_IDLE;
        end else if (sel_ack) begin
          cap_en    = 1'b1;
          state_nxt = S_RESP;
        end else if (tmr == 16'd0) begin
          err_inc   = 1'b1;
          state_nxt = S_ERR;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      io_wbs_adr_p   <= '0;
      io_wbs_datwr_p <= '0;
      io_wbs_we_p    <= 1'b0;
      io_wbs_sel_p   <= '0;
      idx            <= '0;
      tmr            <= '0;
      cap            <= '0;
      err_cnt_o      <= '0;
    end else begin
      if (latch) begin
        io_wbs_adr_p   <= io_wbs_adr;
        io_wbs_datwr_p <= io_wbs_datwr;
        io_wbs_we_p    <= io_wbs_we;
        io_wbs_sel_p   <= io_wbs_sel;
        idx            <= adr_idx;
        tmr            <= TMR_LOAD;
      end else if (tmr_dec) begin
        tmr <= tmr - 16'd1;
      end
      if (cap_en) cap <= sel_dat;
      if (err_inc && (err_cnt_o != 8'hFF)) err_cnt_o <= err_cnt_o + 8'd1;
    end
  end

  always_comb begin
    io_wbs_ack   = (state == S_RESP) || (state == S_ERR);
    err_o        = (state == S_ERR);
    io_wbs_stb_p = (state == S_WAIT) ? onehot : '0;
    io_wbs_cyc_p = (state == S_WAIT) ? onehot : '0;
    case (state)
      S_RESP:  io_wbs_datrd = cap;
      S_ERR:   io_wbs_datrd = ERR_DATA;
      default: io_wbs_datrd = '0;
    endcase
  end

endmodule

// File: tb/tb_wb_mux_n.sv
// Directed bench for wb_mux_n with five slaves, so indices 5..7 are unmapped.
// Stimulus tasks state the expected per-cycle timeline; a negedge process compares it.
module tb_wb_mux_n;
  localparam int          NP       = 5;
  localparam int          TO       = 255;
  localparam logic [31:0] ERR_DATA = 32'hBADC0FFE;

  logic          clk, rst_n;
  logic [31:0]   adr, datwr, datrd;
  logic          we, stb, cyc, ack;
  logic [3:0]    sel;
  logic [31:0]   adr_p, datwr_p;
  logic          we_p;
  logic [3:0]    sel_p;
  logic [NP-1:0] stb_p, cyc_p, ack_p;
  logic [NP*32-1:0] datrd_p;
  logic          err_o;
  logic [7:0]    err_cnt;

  wb_mux_n #(.NUM_PERIPH(NP), .ADDR_W(32), .DATA_W(32), .DEC_LSB(24),
             .TIMEOUT(TO), .ERR_DATA(ERR_DATA)) dut (
    .io_wbs_clk(clk), .io_wbs_rst_n(rst_n),
    .io_wbs_adr(adr), .io_wbs_datwr(datwr), .io_wbs_datrd(datrd),
    .io_wbs_we(we), .io_wbs_sel(sel), .io_wbs_stb(stb), .io_wbs_cyc(cyc),
    .io_wbs_ack(ack),
    .io_wbs_adr_p(adr_p), .io_wbs_datwr_p(datwr_p), .io_wbs_we_p(we_p),
    .io_wbs_sel_p(sel_p), .io_wbs_stb_p(stb_p), .io_wbs_cyc_p(cyc_p),
    .io_wbs_ack_p(ack_p), .io_wbs_datrd_p(datrd_p),
    .err_o(err_o), .err_cnt_o(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0, n_pass = 0;
  bit chk_en = 0;

  // expected outputs for the current cycle
  logic          e_ack, e_err;
  logic [31:0]   e_datrd, e_adr_p, e_datwr_p;
  logic          e_we_p;
  logic [3:0]    e_sel_p;
  logic [NP-1:0] e_stb;
  logic [7:0]    e_cnt;

  // observations for literal checks
  int          n_acks = 0, stb_run = 0, last_run = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", ack, e_ack);
      chk("datrd", datrd, e_datrd);
      chk("err_o", err_o, e_err);
      chk("err_cnt", err_cnt, e_cnt);
      chk("stb_p", stb_p, e_stb);
      chk("cyc_p", cyc_p, e_stb);
      chk("adr_p", adr_p, e_adr_p);
      chk("datwr_p", datwr_p, e_datwr_p);
      chk("we_p", we_p, e_we_p);
      chk("sel_p", sel_p, e_sel_p);
    end
    if (ack === 1'b1) begin
      n_acks++;
      last_rd = datrd;
    end
    if (stb_p != '0) stb_run++;
    else if (stb_run != 0) begin
      last_run = stb_run;
      stb_run  = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    e_ack = 1'b0; e_err = 1'b0; e_datrd = '0; e_stb = '0;
  endtask

  task automatic bump_err();
    if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[26:24]);
  endfunction

  // d >= 0: slave acks in the (d+1)th cycle of its strobe; d < 0: never acks.
  // abort_at > 0: master drops cyc in that cycle of the strobe.
  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic w,
                      input logic [3:0] s, input int d, input logic [31:0] sd,
                      input int abort_at, input bit noise);
    int ix, last;
    logic [NP-1:0] me;
    ix = idx_of(a);
    me = NP'(1) << ix;
    adr = a; datwr = wd; we = w; sel = s; cyc = 1'b1; stb = 1'b1; ack_p = '0;
    set_idle_exp();
    step();
    e_adr_p = a; e_datwr_p = wd; e_we_p = w; e_sel_p = s;
    if (ix >= NP) begin
      e_ack = 1'b1; e_datrd = ERR_DATA; e_err = 1'b1; bump_err();
      step();
      cyc = 1'b0; stb = 1'b0; set_idle_exp();
      step();
    end else begin
      datrd_p[ix*32 +: 32] = sd;
      last = (abort_at > 0) ? abort_at : (d >= 0) ? d + 1 : TO;
      for (int c = 1; c <= last; c++) begin
        set_idle_exp();
        e_stb = me;
        ack_p = noise ? ~me : '0;
        if (abort_at > 0 && c == abort_at) begin
          cyc = 1'b0; ack_p = me;
        end else if (abort_at == 0 && d >= 0 && c == d + 1) begin
          ack_p = me;
        end
        step();
      end
      ack_p = '0;
      if (abort_at > 0) begin
        set_idle_exp();
        step();
        stb = 1'b0;
        step();
      end else begin
        e_stb = '0; e_ack = 1'b1;
        if (d >= 0) begin
          e_datrd = sd; e_err = 1'b0;
        end else begin
          e_datrd = ERR_DATA; e_err = 1'b1; bump_err();
        end
        step();
        cyc = 1'b0; stb = 1'b0; set_idle_exp();
        step();
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  int a0;

  initial begin
    rst_n = 1'b0; adr = '0; datwr = '0; we = 1'b0; sel = '0; stb = 1'b0; cyc = 1'b0;
    ack_p = '0;
    for (int i = 0; i < NP; i++) datrd_p[i*32 +: 32] = 32'h5000_0000 | 32'(i);
    set_idle_exp();
    e_adr_p = '0; e_datwr_p = '0; e_we_p = 1'b0; e_sel_p = '0; e_cnt = '0;
    #1 chk_en = 1;
    step();
    step();
    rst_n = 1'b1;
    step();

    // read slave 2, ack two cycles after strobe, with acks from other slaves meanwhile
    a0 = n_acks;
    xfer(32'h0200_0010, 32'h0, 1'b0, 4'hF, 2, 32'h1234_5678, 0, 1'b1);
    chk("rd2_acks", 64'(n_acks - a0), 64'd1);
    chk("rd2_data", last_rd, 32'h1234_5678);
    chk("rd2_stb_cycles", 64'(last_run), 64'd3);

    // write slave 0
    a0 = n_acks;
    xfer(32'h0000_0004, 32'hA5A5_A5A5, 1'b1, 4'b0011, 1, 32'h0, 0, 1'b0);
    chk("wr0_acks", 64'(n_acks - a0), 64'd1);
    chk("wr0_adr_p", adr_p, 32'h0000_0004);
    chk("wr0_datwr_p", datwr_p, 32'hA5A5_A5A5);
    chk("wr0_sel_p", sel_p, 4'b0011);
    chk("wr0_we_p", we_p, 1'b1);

    // minimum latency on the highest slave
    xfer(32'h0400_0000, 32'h0, 1'b0, 4'hF, 0, 32'hCAFE_F00D, 0, 1'b0);
    chk("rd4_stb_cycles", 64'(last_run), 64'd1);
    chk("rd4_data", last_rd, 32'hCAFE_F00D);

    // unmapped read and write
    a0 = n_acks;
    xfer(32'h0500_0000, 32'h0, 1'b0, 4'hF, 0, 32'h0, 0, 1'b0);
    chk("unm_rd_data", last_rd, 32'hBADC_0FFE);
    chk("unm_rd_cnt", err_cnt, 8'd1);
    xfer(32'h0700_0000, 32'hFFFF_FFFF, 1'b1, 4'hF, 0, 32'h0, 0, 1'b0);
    chk("unm_wr_cnt", err_cnt, 8'd2);
    chk("unm_acks", 64'(n_acks - a0), 64'd2);

    // slave 1 never acks
    xfer(32'h0100_0000, 32'h0, 1'b0, 4'hF, -1, 32'h0, 0, 1'b0);
    chk("to_stb_cycles", 64'(last_run), 64'd255);
    chk("to_data", last_rd, 32'hBADC_0FFE);
    chk("to_cnt", err_cnt, 8'd3);

    // abort on slave 3 with a coincident slave ack
    a0 = n_acks;
    xfer(32'h0300_0000, 32'h0, 1'b0, 4'hF, 5, 32'h7777_7777, 3, 1'b0);
    chk("abort_acks", 64'(n_acks - a0), 64'd0);
    chk("abort_cnt", err_cnt, 8'd3);
    chk("abort_stb_cycles", 64'(last_run), 64'd3);

    // idle ignores slave acks and stb without cyc, and cyc without stb
    a0 = n_acks;
    adr = 32'h0200_0000; stb = 1'b1; cyc = 1'b0; ack_p = '1;
    for (int i = 0; i < 3; i++) step();
    stb = 1'b0; cyc = 1'b1;
    for (int i = 0; i < 2; i++) step();
    cyc = 1'b0; ack_p = '0;
    step();
    chk("idle_acks", 64'(n_acks - a0), 64'd0);

    xfer(32'h0300_0040, 32'h0, 1'b0, 4'hF, 4, 32'h0BAD_F00D, 0, 1'b0);
    chk("rd3_data", last_rd, 32'h0BAD_F00D);

    // saturation
    for (int i = 0; i < 256; i++)
      xfer(32'h0600_0000 | 32'(i), 32'h0, 1'b0, 4'hF, 0, 32'h0, 0, 1'b0);
    chk("sat_cnt", err_cnt, 8'd255);

    // async reset in the middle of a WAIT
    a0 = n_acks;
    adr = 32'h0200_0020; datwr = '0; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    set_idle_exp();
    step();
    e_adr_p = 32'h0200_0020; e_datwr_p = '0; e_we_p = 1'b0; e_sel_p = 4'hF;
    e_stb = 5'b00100;
    step();
    step();
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
    set_idle_exp();
    e_adr_p = '0; e_datwr_p = '0; e_we_p = 1'b0; e_sel_p = '0; e_cnt = '0;
    #1;
    chk("rst_async_stb", stb_p, 5'b00000);
    chk("rst_async_cnt", err_cnt, 8'd0);
    chk("rst_async_adr_p", adr_p, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_acks", 64'(n_acks - a0), 64'd0);

    xfer(32'h0100_0008, 32'h0, 1'b0, 4'hF, 1, 32'h600D_CAFE, 0, 1'b0);
    chk("post_rst_data", last_rd, 32'h600D_CAFE);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
